// File: rtl/inst_fetch_queue_if.sv
// Fetch-queue bus: instruction ROM port, redirect input and issue-side handshake.
// The queue drives the master modport; the ROM/issue/branch environment drives the slave modport.
interface inst_fetch_queue_if #(
   parameter int DEPTH = 4
);
   logic                     rom_nrd;
   logic [31:0]              rom_addr;
   logic [31:0]              rom_data;
   logic                     flush;
   logic [31:0]              flush_pc;
   logic                     deq_ready;
   logic                     inst_valid;
   logic [31:0]              inst;
   logic [31:0]              inst_pc;
   logic [$clog2(DEPTH):0]   count;
   logic                     fetch_done;

   modport master (
      output rom_nrd,
      output rom_addr,
      input  rom_data,
      input  flush,
      input  flush_pc,
      input  deq_ready,
      output inst_valid,
      output inst,
      output inst_pc,
      output count,
      output fetch_done
   );

   modport slave (
      input  rom_nrd,
      input  rom_addr,
      output rom_data,
      output flush,
      output flush_pc,
      output deq_ready,
      input  inst_valid,
      input  inst,
      input  inst_pc,
      input  count,
      input  fetch_done
   );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch controller: owns the PC, reads one ROM word per cycle
// into a show-ahead FIFO drained by issue, with branch redirect support.
module inst_fetch_queue #(
   parameter int          DEPTH     = 4,
   parameter logic [31:0] RESET_PC  = 32'h0,
   parameter int          ROM_BYTES = 100
) (
   input  logic               clk,
   input  logic               nRST,
   inst_fetch_queue_if.master bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
   } ent_t;

   ent_t          q [DEPTH];
   logic [31:0]   pc;
   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic [CW-1:0] cnt;

   logic          empty;
   logic          full;
   logic          done;
   logic          deq;
   logic          fetch;
   logic [32:0]   pc_end;

   // 33-bit sum so a PC near 2^32 cannot wrap back into the ROM image
   assign pc_end = {1'b0, pc} + 33'd3;
   assign done   = pc_end >= 33'(ROM_BYTES);
   assign empty  = cnt == '0;
   assign full   = cnt == CW'(DEPTH);

   assign deq   = ~empty & bus.deq_ready & ~bus.flush;
   assign fetch = nRST & ~bus.flush & ~done & (~full | deq);

   assign bus.rom_nrd    = ~fetch;
   assign bus.rom_addr   = pc;
   assign bus.fetch_done = done;
   assign bus.inst_valid = ~empty;
   assign bus.inst       = q[head].inst;
   assign bus.inst_pc    = q[head].pc;
   assign bus.count      = cnt;

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         pc   <= RESET_PC;
         head <= '0;
         tail <= '0;
         cnt  <= '0;
      end else if (bus.flush) begin
         pc   <= bus.flush_pc & ~32'h3;
         head <= '0;
         tail <= '0;
         cnt  <= '0;
      end else begin
         if (fetch) begin
            pc   <= pc + 32'd4;
            tail <= tail + AW'(1);
         end
         if (deq) begin
            head <= head + AW'(1);
         end
         unique case (1'b1)
            fetch & ~deq: cnt <= cnt + CW'(1);
            deq & ~fetch: cnt <= cnt - CW'(1);
            default:      cnt <= cnt;
         endcase
      end
   end

   // Storage is deliberately left unreset; only occupied slots are ever read
   always_ff @(posedge clk) begin
      if (fetch) begin
         q[tail] <= '{inst: bus.rom_data, pc: pc};
      end
   end

   a_cnt_range : assert property (
      @(posedge clk) disable iff (!nRST) cnt <= CW'(DEPTH)
   );
endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Instruction fetch controller and buffer for the Tomasulo core. It owns the program counter and drives the byte-addressed, big-endian, active-low-read instruction ROM, issuing one 32-bit fetch per cycle. Fetched words go into a small FIFO that the issue stage drains with a valid/ready handshake. The block also handles redirect (flush) requests from branch resolution and stops fetching at the end of the ROM image.

## Interface
- `DEPTH`, 4: number of queue entries; must be a power of 2 and at least 2.
- `RESET_PC`, 32'h0: PC loaded on reset; must be word-aligned.
- `ROM_BYTES`, 100: ROM size in bytes. A fetch is legal only while `pc + 3 < ROM_BYTES`.
- `clk  in  1`: single clock. All state updates on the rising edge.
- `nRST  in  1`: asynchronous, active-low reset.
- `rom_nrd  out  1`: ROM read enable, active-low, combinational.
- `rom_addr  out  32`: ROM byte address; always equals `pc`.
- `rom_data  in  32`: ROM read data; valid in the same cycle that `rom_nrd` is 0.
- `flush  in  1`: redirect request from branch resolution.
- `flush_pc  in  32`: redirect target address.
- `deq_ready  in  1`: issue stage can accept the head entry.
- `inst_valid  out  1`: queue is not empty.
- `inst  out  32`: instruction word at the head of the queue.
- `inst_pc  out  32`: PC of the head entry.
- `count  out  $clog2(DEPTH)+1`: current number of occupied entries.
- `fetch_done  out  1`: PC has run past the end of the ROM image.

## Operation
- State:
  - `pc`.
  - Queue storage: `DEPTH` entries, each holding {instruction, PC}.
  - Head and tail pointers, each `$clog2(DEPTH)` bits, wrapping modulo `DEPTH`.
  - `count`.
- `deq = inst_valid & deq_ready & ~flush`.
- `fetch = ~flush & ~fetch_done & (count < DEPTH | deq)`. A full queue may fetch in the same cycle it dequeues.
- `rom_nrd = ~fetch` (combinational). Held at 1 while `nRST = 0`.
- `fetch_done = (pc + 3 >= ROM_BYTES)`, computed combinationally from `pc`.
- On `fetch`:
  - Write {`rom_data`, `pc`} at the tail.
  - Advance the tail pointer.
  - `pc <= pc + 4` (32-bit wrap).
- On `deq`: advance the head pointer.
- `count` update:
  - +1 on fetch only.
  - −1 on deq only.
  - Unchanged when both or neither occur.
- On `flush`, which has priority over everything:
  - Head, tail and `count` reset to 0; all queued entries are discarded.
  - `pc <= {flush_pc[31:2], 2'b00}`.
  - No fetch and no dequeue occur that cycle, even if `deq_ready = 1`.
- Once `fetch_done` is set, `pc` holds until the next flush or reset. The queue keeps draining normally.
- `inst` and `inst_pc` are taken from the head entry (show-ahead FIFO). When `inst_valid = 0` they are don't-care.

## Timing
- Reset values:
  - `pc = RESET_PC`; pointers = 0; `count = 0`.
  - `inst_valid = 0`; `rom_nrd = 1`.
  - `rom_addr = RESET_PC`.
  - `fetch_done` is derived from `RESET_PC`.
  - Storage contents are not reset.
- Reset mid-operation: everything returns to reset values immediately (asynchronous), regardless of `flush` or queue state.
- Fetch-to-visible latency is 1 cycle: an instruction fetched at edge N appears at the head (if the queue was empty) after edge N, with `inst_valid = 1` in cycle N+1.
- Steady state with `deq_ready` held at 1: one fetch and one dequeue every cycle, and `count` stays at 1.
- With `deq_ready = 0`, the queue fills in `DEPTH` cycles. `rom_nrd` then stays at 1 until an entry leaves.
- After a flush: the first fetch from `flush_pc` happens at the next edge, and `inst_valid` rises one cycle after that.

## Test plan
- **Reset, free-running drain.** Release `nRST` with ROM = words W0..W24 and `deq_ready = 1`.
  - Required: `inst` = W0, W1, … on consecutive cycles.
  - Required: `inst_pc` = 0, 4, 8, … on the same cycles.
  - Required: after PC 96 is fetched, `fetch_done = 1`, `rom_nrd` stays at 1, and the queue drains to `inst_valid = 0`.
- **Fill and stall.** Hold `deq_ready = 0`.
  - Required: after 4 edges, `count = 4` and `rom_nrd = 1`, with `pc` held at 16.
  - Raise `deq_ready` for 1 cycle. Required: W0 leaves, W4 is enqueued in the same cycle, and `count` stays at 4.
- **Flush with full queue.** Assert `flush` with `flush_pc = 32'h2B`.
  - Required next cycle: `count = 0`, `inst_valid = 0`, `rom_addr = 32'h28`.
  - Required one cycle later: `inst = W10` and `inst_pc = 32'h28`.
- **Flush vs. deq same cycle.** Use `count = 2` and assert `flush` together with `deq_ready = 1`.
  - Required: no dequeue is counted, the queue is emptied, and there is no underflow (`count = 0`, not wrapped).
- **Flush past end.** Set `flush_pc = 96`.
  - Required: exactly one fetch (W24), then `fetch_done = 1`.
  - Set `flush_pc = 100`. Required: `fetch_done = 1` immediately and no fetch occurs.
- **Async reset mid-stream.** Pulse `nRST` low between edges while `count = 3`.
  - Required: `inst_valid`, `count` and `pc` clear without waiting for a clock edge, and `rom_nrd = 1`.
